// File: rtl/controller_sequencer.sv
// SAP-1 controller-sequencer: a fixed T1..T7 ring with INIT and an absorbing HALT.
// Control lines are decoded from the state register and the current opcode.
module controller_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] controller_input,
  output logic       pc_to_bus,
  output logic       inc_pc,
  output logic       load_mar,
  output logic       ram_to_bus,
  output logic       load_i,
  output logic       output_to_bus,
  output logic       load_a,
  output logic       a_to_bus,
  output logic       sub,
  output logic       alu_to_bus,
  output logic       load_b,
  output logic       load_out,
  output logic       halted,
  output logic [3:0] t_state
);

  localparam int unsigned STATE_W = 4;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [STATE_W-1:0] {
    S_INIT = 4'd0,
    S_T1   = 4'd1,
    S_T2   = 4'd2,
    S_T3   = 4'd3,
    S_T4   = 4'd4,
    S_T5   = 4'd5,
    S_T6   = 4'd6,
    S_T7   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  state_t state, state_next;

  // State register; reset drops straight to INIT so every output clears at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_INIT;
    else       state <= state_next;
  end

  // Next-state and control decode.
  always_comb begin
    state_next    = S_INIT;
    pc_to_bus     = 1'b0;
    inc_pc        = 1'b0;
    load_mar      = 1'b0;
    ram_to_bus    = 1'b0;
    load_i        = 1'b0;
    output_to_bus = 1'b0;
    load_a        = 1'b0;
    a_to_bus      = 1'b0;
    sub           = 1'b0;
    alu_to_bus    = 1'b0;
    load_b        = 1'b0;
    load_out      = 1'b0;
    halted        = 1'b0;

    case (state)
      S_INIT: state_next = S_T1;
      S_T1: begin
        state_next = S_T2;
        pc_to_bus  = 1'b1;
        load_mar   = 1'b1;
      end
      S_T2: begin
        state_next = S_T3;
        inc_pc     = 1'b1;
      end
      S_T3: begin
        state_next = S_T4;
        ram_to_bus = 1'b1;
        load_i     = 1'b1;
      end
      // Opcode nibble is still settling in the instruction register here.
      S_T4: state_next = S_T5;
      S_T5: begin
        state_next = S_T6;
        case (controller_input)
          OP_LDA, OP_ADD, OP_SUB: begin
            output_to_bus = 1'b1;
            load_mar      = 1'b1;
          end
          OP_OUT: begin
            a_to_bus = 1'b1;
            load_out = 1'b1;
          end
          OP_HLT: begin
            halted     = 1'b1;
            state_next = S_HALT;
          end
          default: ;
        endcase
      end
      S_T6: begin
        state_next = S_T7;
        case (controller_input)
          OP_LDA: begin
            ram_to_bus = 1'b1;
            load_a     = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ram_to_bus = 1'b1;
            load_b     = 1'b1;
          end
          default: ;
        endcase
      end
      S_T7: begin
        state_next = S_T1;
        if (controller_input == OP_ADD || controller_input == OP_SUB) begin
          alu_to_bus = 1'b1;
          load_a     = 1'b1;
          sub        = (controller_input == OP_SUB);
        end
      end
      S_HALT: begin
        state_next = S_HALT;
        halted     = 1'b1;
      end
      default: state_next = S_INIT;
    endcase
  end

  assign t_state = STATE_W'(state);

endmodule

// File: tb/tb_controller_sequencer.sv
// Directed and randomised checks of the SAP-1 controller-sequencer control lines.
module tb_controller_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] controller_input;
  logic pc_to_bus, inc_pc, load_mar, ram_to_bus, load_i, output_to_bus, load_a;
  logic a_to_bus, sub, alu_to_bus, load_b, load_out, halted;
  logic [3:0] t_state;

  int total = 0;
  int bad   = 0;

  controller_sequencer dut (
    .clock(clock), .reset(reset), .controller_input(controller_input),
    .pc_to_bus(pc_to_bus), .inc_pc(inc_pc), .load_mar(load_mar),
    .ram_to_bus(ram_to_bus), .load_i(load_i), .output_to_bus(output_to_bus),
    .load_a(load_a), .a_to_bus(a_to_bus), .sub(sub), .alu_to_bus(alu_to_bus),
    .load_b(load_b), .load_out(load_out), .halted(halted), .t_state(t_state)
  );

  always #5 clock = ~clock;

  localparam logic [12:0] EP = 13'h1000, CP = 13'h0800, LM = 13'h0400, CE = 13'h0200;
  localparam logic [12:0] LI = 13'h0100, EI = 13'h0080, LA = 13'h0040, EA = 13'h0020;
  localparam logic [12:0] SU = 13'h0010, EU = 13'h0008, LB = 13'h0004, LO = 13'h0002;
  localparam logic [12:0] HL = 13'h0001, NONE = 13'h0000;

  logic [12:0] obs;
  logic [4:0]  drivers;
  assign obs = {pc_to_bus, inc_pc, load_mar, ram_to_bus, load_i, output_to_bus,
                load_a, a_to_bus, sub, alu_to_bus, load_b, load_out, halted};
  assign drivers = {pc_to_bus, ram_to_bus, output_to_bus, a_to_bus, alu_to_bus};

  task automatic chk(input string tag, input logic [16:0] o, input logic [16:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check(input string tag, input logic [3:0] et, input logic [12:0] ev);
    chk(tag, {t_state, obs}, {et, ev});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Steps from T1 (already checked) through T2 and T3.
  task automatic fetch(input string tag);
    step(); check({tag, "_t2"}, 4'd2, CP);
    step(); check({tag, "_t3"}, 4'd3, CE | LI);
  endtask

  function automatic logic [3:0] model_next(input logic [3:0] s, input logic [3:0] op);
    case (s)
      4'd0: model_next = 4'd1;
      4'd5: model_next = (op == 4'b1111) ? 4'd8 : 4'd6;
      4'd7: model_next = 4'd1;
      4'd8: model_next = 4'd8;
      default: model_next = s + 4'd1;
    endcase
  endfunction

  logic [3:0] m_state;
  int         instr;
  int         cyc;

  initial begin
    reset = 1'b1;
    controller_input = 4'd0;
    #2;
    check("init", 4'd0, NONE);
    @(negedge clock) reset = 1'b0;
    step(); check("first_t1", 4'd1, EP | LM);
    step(); check("first_t2", 4'd2, CP);

    // Asynchronous reset mid-cycle.
    #2 reset = 1'b1;
    #1 check("async_rst", 4'd0, NONE);
    @(negedge clock) reset = 1'b0;
    step(); check("rst_t1", 4'd1, EP | LM);
    fetch("rst");

    // LDA
    controller_input = 4'b0000;
    step(); check("lda_t4", 4'd4, NONE);
    step(); check("lda_t5", 4'd5, EI | LM);
    step(); check("lda_t6", 4'd6, CE | LA);
    step(); check("lda_t7", 4'd7, NONE);
    step(); check("lda_next", 4'd1, EP | LM);

    // ADD then SUB back-to-back
    fetch("add");
    controller_input = 4'b0001;
    step(); check("add_t4", 4'd4, NONE);
    step(); check("add_t5", 4'd5, EI | LM);
    step(); check("add_t6", 4'd6, CE | LB);
    step(); check("add_t7", 4'd7, EU | LA);
    step(); check("add_next", 4'd1, EP | LM);
    fetch("sub");
    controller_input = 4'b0010;
    step(); check("sub_t4", 4'd4, NONE);
    step(); check("sub_t5", 4'd5, EI | LM);
    step(); check("sub_t6", 4'd6, CE | LB);
    step(); check("sub_t7", 4'd7, EU | LA | SU);
    step(); check("sub_next", 4'd1, EP | LM);

    // OUT then NOP
    fetch("out");
    controller_input = 4'b1110;
    step(); check("out_t4", 4'd4, NONE);
    step(); check("out_t5", 4'd5, EA | LO);
    step(); check("out_t6", 4'd6, NONE);
    step(); check("out_t7", 4'd7, NONE);
    step(); check("out_next", 4'd1, EP | LM);
    fetch("nop");
    controller_input = 4'b0101;
    step(); check("nop_t4", 4'd4, NONE);
    step(); check("nop_t5", 4'd5, NONE);
    step(); check("nop_t6", 4'd6, NONE);
    step(); check("nop_t7", 4'd7, NONE);
    step(); check("nop_next", 4'd1, EP | LM);

    // HLT and hold
    fetch("hlt");
    controller_input = 4'b1111;
    step(); check("hlt_t4", 4'd4, NONE);
    step(); check("hlt_t5", 4'd5, HL);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) controller_input = 4'b0000;
      step(); check("hlt_hold", 4'd8, HL);
    end
    #2 reset = 1'b1;
    #1 check("hlt_rst", 4'd0, NONE);
    @(negedge clock) reset = 1'b0;
    step(); check("hlt_rst_t1", 4'd1, EP | LM);

    // Randomised opcodes with injected resets
    m_state = 4'd1;
    instr = 0;
    cyc = 0;
    while (instr < 500 && cyc < 20000) begin
      cyc++;
      chk("rnd_state", 17'(t_state), 17'(m_state));
      chk("rnd_drv1hot", 17'($countones(drivers) <= 1), 17'd1);
      chk("rnd_sub", 17'(sub),
          17'(m_state == 4'd7 && controller_input == 4'b0010));
      if (m_state == 4'd1) chk("rnd_t1", 17'(obs), 17'(EP | LM));
      if (m_state == 4'd8) chk("rnd_halt", 17'(obs), 17'(HL));
      if (m_state == 4'd4) controller_input = 4'($urandom_range(0, 15));
      if (m_state == 4'd7) instr++;
      if (m_state == 4'd8 || $urandom_range(0, 59) == 0) begin
        #1 reset = 1'b1;
        #1 chk("rnd_rst", {t_state, obs}, 17'd0);
        #1 reset = 1'b0;
        m_state = 4'd0;
      end
      step();
      m_state = model_next(m_state, controller_input);
    end
    chk("rnd_budget", 17'(instr >= 500), 17'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
